// File: rtl/mode_cmd_pkg.sv
// Shared types and constants for the mode/data command issuer.
package mode_cmd_pkg;

  // Bus and op-code widths; the request struct and FIFO storage are sized from these.
  localparam int unsigned DW  = 14;
  localparam int unsigned OPW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait
  } cmd_state_e;

  // Mode op codes understood by the decoder.
  localparam logic [OPW-1:0] OpNop    = 3'b000;
  localparam logic [OPW-1:0] OpLoad   = 3'b001;
  localparam logic [OPW-1:0] OpStore  = 3'b010;
  localparam logic [OPW-1:0] OpMode   = 3'b101;
  localparam logic [OPW-1:0] OpReset  = 3'b111;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  data;
    logic           swap;
  } cmd_req_t;

endpackage

// File: rtl/cmd_fifo.sv
// Request FIFO: DEPTH entries of cmd_req_t, registered occupancy count.
module cmd_fifo
  import mode_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  cmd_req_t                 push_data_i,
  input  logic                     pop_i,
  output cmd_req_t                 head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  cmd_req_t            mem_q [DEPTH];
  cmd_req_t            mem_d [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer, count and storage next state; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  // State registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mode_cmd_issuer.sv
// Issues buffered mode/data commands one at a time: setup, strobe, wait for done or timeout.
module mode_cmd_issuer
  import mode_cmd_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPW-1:0]         req_op,
  input  logic [DW-1:0]          req_data,
  input  logic                   req_swap,
  output logic [OPW-1:0]         cmd_op,
  output logic                   cmd_sel,
  output logic [DW-1:0]          cmd_a,
  output logic [DW-1:0]          cmd_b,
  output logic                   cmd_strobe,
  input  logic                   cmd_done,
  output logic                   busy,
  output logic                   err_timeout,
  input  logic                   err_clr,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned FcW    = $clog2(DEPTH) + 1;
  localparam int unsigned CntMax = (SETUP_CYC > TIMEOUT) ? SETUP_CYC : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  cmd_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0]   cmd_op_q, cmd_op_d;
  logic             cmd_sel_q, cmd_sel_d;
  logic [DW-1:0]    cmd_a_q, cmd_a_d;
  logic [DW-1:0]    cmd_b_q, cmd_b_d;
  logic             cmd_strobe_q, cmd_strobe_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             push, pop, timeout_hit;
  cmd_req_t         push_req, head;

  // Ready is decoded from the registered count, so a same-cycle pop never frees a slot.
  assign req_ready = (fifo_count < FcW'(DEPTH));
  assign push      = req_valid & req_ready;
  assign push_req  = '{op: req_op, data: req_data, swap: req_swap};

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_req),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  // Sequencer next state, counter, bus steering and sticky error.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_op_d     = cmd_op_q;
    cmd_sel_d    = cmd_sel_q;
    cmd_a_d      = cmd_a_q;
    cmd_b_d      = cmd_b_q;
    cmd_strobe_d = 1'b0;
    pop          = 1'b0;
    timeout_hit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          cmd_op_d  = head.op;
          cmd_sel_d = head.swap;
          cmd_a_d   = head.swap ? '0 : head.data;
          cmd_b_d   = head.swap ? head.data : '0;
          cnt_d     = '0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SETUP_CYC - 1)) begin
          state_d      = StStrobe;
          cmd_strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStrobe: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (cmd_done) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    // A new timeout wins over a clear in the same cycle.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
  end

  // Registered state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cmd_op_q     <= '0;
      cmd_sel_q    <= 1'b0;
      cmd_a_q      <= '0;
      cmd_b_q      <= '0;
      cmd_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_op_q     <= cmd_op_d;
      cmd_sel_q    <= cmd_sel_d;
      cmd_a_q      <= cmd_a_d;
      cmd_b_q      <= cmd_b_d;
      cmd_strobe_q <= cmd_strobe_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign cmd_op      = cmd_op_q;
  assign cmd_sel     = cmd_sel_q;
  assign cmd_a       = cmd_a_q;
  assign cmd_b       = cmd_b_q;
  assign cmd_strobe  = cmd_strobe_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mode_cmd_issuer.sv
// Directed self-checking bench for mode_cmd_issuer.
module tb_mode_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_swap;
  logic [2:0]  req_op, cmd_op;
  logic [13:0] req_data, cmd_a, cmd_b;
  logic        cmd_sel, cmd_strobe, cmd_done, busy, err_timeout, err_clr;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  mode_cmd_issuer #(
    .DEPTH    (4),
    .SETUP_CYC(2),
    .TIMEOUT  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_swap   (req_swap),
    .cmd_op     (cmd_op),
    .cmd_sel    (cmd_sel),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_strobe (cmd_strobe),
    .cmd_done   (cmd_done),
    .busy       (busy),
    .err_timeout(err_timeout),
    .err_clr    (err_clr),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Present one request for one cycle (caller is at a negedge with ready high).
  task automatic push(input logic [2:0] op, input logic [13:0] data, input logic swap);
    req_op    = op;
    req_data  = data;
    req_swap  = swap;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Advance negedge by negedge until strobe is seen, within a cycle budget.
  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_data = '0; req_swap = 1'b0;
    cmd_done = 1'b0; err_clr = 1'b0;
    #12;
    n_checks++;
    if ({cmd_op, cmd_sel, cmd_a, cmd_b, cmd_strobe, busy, err_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got op=%h sel=%b a=%h b=%h stb=%b busy=%b err=%b, want all 0",
               cmd_op, cmd_sel, cmd_a, cmd_b, cmd_strobe, busy, err_timeout);
    end
    n_checks++;
    if (req_ready !== 1'b1 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_fifo: ready=%b count=%0d, want 1/0", req_ready, fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    push(3'b101, 14'h1A5, 1'b0);
    n_checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pushed: count=%0d busy=%b, want 1/0", fifo_count, busy);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_op !== 3'b101 || cmd_a !== 14'h1A5 || cmd_b !== 14'h0 || cmd_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL single_load: op=%b a=%h b=%h sel=%b, want 101/1a5/0/0",
               cmd_op, cmd_a, cmd_b, cmd_sel);
    end
    n_checks++;
    if (busy !== 1'b1 || fifo_count !== 3'd0 || cmd_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL single_setup: busy=%b count=%0d stb=%b, want 1/0/0",
               busy, fifo_count, cmd_strobe);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_strobe: stb=%b, want 0", cmd_strobe);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL single_strobe_cycle3: stb=%b, want 1", cmd_strobe);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL single_strobe_width: stb=%b, want 0", cmd_strobe);
    end
    @(negedge clk);
    cmd_done = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_wait: busy=%b, want 1", busy);
    end
    @(negedge clk);
    cmd_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || cmd_a !== 14'h1A5 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: busy=%b a=%h err=%b, want 0/1a5/0", busy, cmd_a, err_timeout);
    end
    @(negedge clk);
    ok = 1'b1;
  endtask

  task automatic test_swap;
    bit ok;
    push(3'b010, 14'h3FFF, 1'b1);
    @(negedge clk);
    n_checks++;
    if (cmd_b !== 14'h3FFF || cmd_a !== 14'h0 || cmd_sel !== 1'b1 || cmd_op !== 3'b010) begin
      n_fail++;
      $display("FAIL swap_load: op=%b a=%h b=%h sel=%b, want 010/0/3fff/1",
               cmd_op, cmd_a, cmd_b, cmd_sel);
    end
    wait_strobe(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL swap_strobe_timeout: strobe not seen, want strobe within 40 cycles");
    end
    @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit          ok;
    logic [2:0]  ops   [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
    logic [13:0] datas [5] = '{14'h0111, 14'h0222, 14'h0333, 14'h0444, 14'h0555};
    logic        swaps [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Occupy the sequencer so the FIFO can fill.
    push(3'b111, 14'h0010, 1'b0);
    wait_strobe(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_p0_strobe: strobe not seen, want strobe within 40 cycles");
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: ready=%b, want 1", i, req_ready);
      end
      push(ops[i], datas[i], swaps[i]);
    end
    req_op = ops[4]; req_data = datas[4]; req_swap = swaps[4]; req_valid = 1'b1;
    n_checks++;
    if (req_ready !== 1'b0 || fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_full: ready=%b count=%0d, want 0/4", req_ready, fifo_count);
    end
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_still_full: ready=%b count=%0d, want 0/4", req_ready, fifo_count);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || fifo_count !== 3'd3 || cmd_op !== ops[0]) begin
      n_fail++;
      $display("FAIL b2b_first_pop: ready=%b count=%0d op=%b, want 1/3/%b",
               req_ready, fifo_count, cmd_op, ops[0]);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_fifth_push: count=%0d, want 4", fifo_count);
    end
    for (int k = 0; k < 5; k++) begin
      wait_strobe(ok);
      n_checks++;
      if (!ok || cmd_op !== ops[k] || cmd_sel !== swaps[k] ||
          cmd_a !== (swaps[k] ? 14'h0 : datas[k]) || cmd_b !== (swaps[k] ? datas[k] : 14'h0)) begin
        n_fail++;
        $display("FAIL b2b_order_%0d: seen=%b op=%b sel=%b a=%h b=%h, want 1/%b/%b data=%h",
                 k, ok, cmd_op, cmd_sel, cmd_a, cmd_b, ops[k], swaps[k], datas[k]);
      end
      @(negedge clk);
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit ok;
    push(3'b011, 14'h0AAA, 1'b0);
    push(3'b110, 14'h0BBB, 1'b1);
    wait_strobe(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_strobe: strobe not seen, want strobe within 40 cycles");
    end
    repeat (15) @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_before: err=%b busy=%b, want 0/1", err_timeout, busy);
    end
    @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_set: err=%b busy=%b, want 1/0", err_timeout, busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || cmd_op !== 3'b110 || cmd_b !== 14'h0BBB || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_next_cmd: busy=%b op=%b b=%h err=%b, want 1/110/0bbb/1",
               busy, cmd_op, cmd_b, err_timeout);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: err=%b, want 0", err_timeout);
    end
    wait_strobe(ok);
    repeat (15) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (!ok || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_set_beats_clear: seen=%b err=%b, want 1/1", ok, err_timeout);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_done_ignored;
    bit ok;
    push(3'b001, 14'h0123, 1'b0);
    cmd_done = 1'b1;
    wait_strobe(ok);
    n_checks++;
    if (!ok || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_strobe: seen=%b err=%b, want 1/0", ok, err_timeout);
    end
    @(negedge clk);
    cmd_done = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_still_busy: busy=%b, want 1", busy);
    end
    repeat (14) @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_before: err=%b busy=%b, want 0/1", err_timeout, busy);
    end
    @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_timeout: err=%b busy=%b, want 1/0", err_timeout, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    push(3'b101, 14'h0F0F, 1'b0);
    push(3'b010, 14'h00F0, 1'b1);
    wait_strobe(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || busy !== 1'b1 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_pre: seen=%b busy=%b count=%0d, want 1/1/1", ok, busy, fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({cmd_op, cmd_sel, cmd_a, cmd_b, cmd_strobe, busy, err_timeout} !== '0 ||
        req_ready !== 1'b1 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_wait: op=%b a=%h busy=%b err=%b ready=%b count=%0d, want 0s/1/0",
               cmd_op, cmd_a, busy, err_timeout, req_ready, fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_flushed: busy=%b count=%0d, want 0/0", busy, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_swap();
    test_back_to_back();
    test_timeout();
    test_done_ignored();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
